// File: rtl/alu_pkg.sv
// Shared ALU definitions: default datapath width, result-stage state
// encoding and the {zero, neg, carry, ovf} flag bundle layout used by the
// result stage, writeback and branch units.
package alu_pkg;

   localparam int unsigned ALU_N = 32;

   // Result-stage occupancy; 2'b11 is illegal and recovers to ST_EMPTY.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_TWO   = 2'b10
   } stage_state_e;

   // Flag bundle bit positions, constant-indexed.
   localparam int unsigned FLAG_W     = 4;
   localparam int unsigned FLAG_ZERO  = 3;
   localparam int unsigned FLAG_NEG   = 2;
   localparam int unsigned FLAG_CARRY = 1;
   localparam int unsigned FLAG_OVF   = 0;

   typedef logic [FLAG_W-1:0] alu_flags_t;

   // Assemble a flag bundle in the shared layout.
   function automatic alu_flags_t pack_flags(input logic zero,
                                             input logic neg,
                                             input logic carry,
                                             input logic ovf);
      alu_flags_t f;
      f             = '0;
      f[FLAG_ZERO]  = zero;
      f[FLAG_NEG]   = neg;
      f[FLAG_CARRY] = carry;
      f[FLAG_OVF]   = ovf;
      return f;
   endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Combinational zero/negative flag generator for an N-bit result.
// Ports:
//   result  - N-bit value to inspect
//   zero_c  - 1 when result is all zeros
//   neg_c   - result MSB (two's-complement sign)
module alu_flag_gen #(
   parameter int unsigned N = 32
) (
   input  logic [N-1:0] result,
   output logic         zero_c,
   output logic         neg_c
);

   assign zero_c = ~|result;
   assign neg_c  = result[N-1];

endmodule

// File: rtl/alu_result_stage.sv
// Registered ALU output stage with a 2-entry skid buffer. Captures the ALU
// result with zero/neg flags and forwarded carry/ovf, and hands it to the
// writeback consumer over valid/ready. in_ready depends only on registered
// state, never combinationally on out_ready.
// Ports:
//   clk, rst_n                   - clock, async active-low reset
//   in_valid/in_ready            - ALU-side handshake
//   in_result, in_carry, in_ovf  - ALU result and adder flags
//   out_valid/out_ready          - consumer-side handshake
//   out_result, out_zero, out_neg, out_carry, out_ovf - registered result
//   xfer_count                   - completed output transfers (wraps)
module alu_result_stage
   import alu_pkg::*;
#(
   parameter int unsigned N     = ALU_N,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_result,
   input  logic             in_carry,
   input  logic             in_ovf,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_result,
   output logic             out_zero,
   output logic             out_neg,
   output logic             out_carry,
   output logic             out_ovf,
   output logic [CNT_W-1:0] xfer_count
);

   stage_state_e state_q;
   stage_state_e state_d;

   logic [N-1:0] m_result_q;
   alu_flags_t   m_flags_q;
   logic [N-1:0] s_result_q;
   alu_flags_t   s_flags_q;

   logic       in_zero_c;
   logic       in_neg_c;
   alu_flags_t in_flags_c;

   logic accept_c;
   logic xfer_c;
   logic load_m_in_c;
   logic load_m_skid_c;
   logic load_s_c;

   // Flags are generated at capture time so the output path is flop-only.
   alu_flag_gen #(
      .N(N)
   ) u_flag_gen (
      .result (in_result),
      .zero_c (in_zero_c),
      .neg_c  (in_neg_c)
   );

   assign in_flags_c = pack_flags(in_zero_c, in_neg_c, in_carry, in_ovf);

   assign accept_c = in_valid & in_ready;
   assign xfer_c   = out_valid & out_ready;

   // Next-state and load selects.
   always_comb begin
      state_d       = state_q;
      load_m_in_c   = 1'b0;
      load_m_skid_c = 1'b0;
      load_s_c      = 1'b0;
      case (state_q)
         ST_EMPTY: begin
            if (accept_c) begin
               load_m_in_c = 1'b1;
               state_d     = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept_c && !xfer_c) begin
               load_s_c = 1'b1;
               state_d  = ST_TWO;
            end else if (accept_c && xfer_c) begin
               load_m_in_c = 1'b1;
            end else if (xfer_c) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            // in_ready is low here, so only a drain can occur.
            if (xfer_c) begin
               load_m_skid_c = 1'b1;
               state_d       = ST_ONE;
            end
         end
         default: begin
            state_d = ST_EMPTY;
         end
      endcase
   end

   // State, handshake outputs, main/skid registers and transfer counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_EMPTY;
         out_valid  <= 1'b0;
         in_ready   <= 1'b1;
         m_result_q <= '0;
         m_flags_q  <= '0;
         s_result_q <= '0;
         s_flags_q  <= '0;
         xfer_count <= '0;
      end else begin
         state_q   <= state_d;
         out_valid <= (state_d != ST_EMPTY);
         in_ready  <= (state_d != ST_TWO);
         if (load_m_in_c) begin
            m_result_q <= in_result;
            m_flags_q  <= in_flags_c;
         end else if (load_m_skid_c) begin
            m_result_q <= s_result_q;
            m_flags_q  <= s_flags_q;
         end
         if (load_s_c) begin
            s_result_q <= in_result;
            s_flags_q  <= in_flags_c;
         end
         if (xfer_c) begin
            xfer_count <= xfer_count + CNT_W'(1);
         end
      end
   end

   assign out_result = m_result_q;
   assign out_zero   = m_flags_q[FLAG_ZERO];
   assign out_neg    = m_flags_q[FLAG_NEG];
   assign out_carry  = m_flags_q[FLAG_CARRY];
   assign out_ovf    = m_flags_q[FLAG_OVF];

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: a two-deep FIFO queue model of
// the stage, checked every cycle, plus literal expectations for directed
// scenarios.
module tb_alu_result_stage;

   localparam int unsigned N     = 32;
   localparam int unsigned CNT_W = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_result;
   logic             in_carry;
   logic             in_ovf;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_result;
   logic             out_zero;
   logic             out_neg;
   logic             out_carry;
   logic             out_ovf;
   logic [CNT_W-1:0] xfer_count;

   always #5 clk = ~clk;

   alu_result_stage #(
      .N     (N),
      .CNT_W (CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_result  (in_result),
      .in_carry   (in_carry),
      .in_ovf     (in_ovf),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_zero   (out_zero),
      .out_neg    (out_neg),
      .out_carry  (out_carry),
      .out_ovf    (out_ovf),
      .xfer_count (xfer_count)
   );

   typedef struct {
      logic [N-1:0] res;
      logic         carry;
      logic         ovf;
   } entry_t;

   entry_t           mq[$];
   logic [CNT_W-1:0] mcount;
   int               errors = 0;
   int               checks = 0;

   task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Compare DUT outputs against the queue model: the head of the queue is
   // what must be presented, flags derived from its value.
   task automatic check_model();
      chk("model out_valid", N'(out_valid), N'(mq.size() > 0));
      chk("model in_ready", N'(in_ready), N'(mq.size() < 2));
      chk("model xfer_count", N'(xfer_count), N'(mcount));
      if (mq.size() > 0) begin
         chk("model out_result", out_result, mq[0].res);
         chk("model out_zero", N'(out_zero), N'(mq[0].res == '0));
         chk("model out_neg", N'(out_neg), N'(mq[0].res[N-1]));
         chk("model out_carry", N'(out_carry), N'(mq[0].carry));
         chk("model out_ovf", N'(out_ovf), N'(mq[0].ovf));
      end
   endtask

   // Advance one clock: update the model with the inputs in effect at the
   // coming edge, then check on the following falling edge.
   task automatic tick();
      bit     acc;
      bit     xf;
      entry_t e;
      if (!rst_n) begin
         mq.delete();
         mcount = '0;
      end else begin
         acc = in_valid && (mq.size() < 2);
         xf  = (mq.size() > 0) && out_ready;
         if (xf) begin
            void'(mq.pop_front());
            mcount = mcount + CNT_W'(1);
         end
         if (acc) begin
            e.res   = in_result;
            e.carry = in_carry;
            e.ovf   = in_ovf;
            mq.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
      check_model();
   endtask

   task automatic drive(input logic v, input logic [N-1:0] r, input logic c, input logic o);
      in_valid  = v;
      in_result = r;
      in_carry  = c;
      in_ovf    = o;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      out_ready = 1'b0;
      mcount    = '0;
      drive(1'b0, '0, 1'b0, 1'b0);

      // Reset held with in_valid asserted.
      drive(1'b1, $urandom, 1'b1, 1'b1);
      repeat (3) begin
         tick();
         chk("rst out_valid", N'(out_valid), 32'd0);
         chk("rst in_ready", N'(in_ready), 32'd1);
         chk("rst out_result", out_result, 32'd0);
         chk("rst xfer_count", N'(xfer_count), 32'd0);
      end
      rst_n = 1'b1;
      drive(1'b0, $urandom, 1'b0, 1'b0);

      // Single result.
      out_ready = 1'b1;
      drive(1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
      tick();
      chk("single out_valid", N'(out_valid), 32'd1);
      chk("single out_result", out_result, 32'hFFFF_FFFF);
      chk("single neg", N'(out_neg), 32'd1);
      chk("single zero", N'(out_zero), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      chk("single drained", N'(out_valid), 32'd0);
      chk("single count", N'(xfer_count), 32'd1);

      // Backpressure and skid.
      out_ready = 1'b0;
      drive(1'b1, 32'h0000_0000, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h1234_5678, 1'b0, 1'b0);
      tick();
      chk("skid in_ready full", N'(in_ready), 32'd0);
      chk("skid head", out_result, 32'h0000_0000);
      drive(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
      tick();
      chk("skid held in_ready", N'(in_ready), 32'd0);
      chk("skid held result", out_result, 32'h0000_0000);
      chk("skid held zero", N'(out_zero), 32'd1);
      out_ready = 1'b1;
      tick();
      chk("skid drain 2", out_result, 32'h1234_5678);
      chk("skid drain in_ready", N'(in_ready), 32'd1);
      tick();
      chk("skid drain 3", out_result, 32'hDEAD_BEEF);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      // Three skid transfers on top of the single-result transfer.
      chk("skid count", N'(xfer_count), 32'd4);
      chk("skid empty", N'(out_valid), 32'd0);

      // Streaming at full rate.
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, N'(i), 1'b0, 1'b0);
         tick();
         chk("stream in_ready", N'(in_ready), 32'd1);
         chk("stream result", out_result, N'(i));
      end
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();
      chk("stream count", N'(xfer_count), 32'd12);

      // Flag passthrough.
      drive(1'b1, 32'h8000_0000, 1'b1, 1'b1);
      tick();
      chk("flags neg", N'(out_neg), 32'd1);
      chk("flags zero", N'(out_zero), 32'd0);
      chk("flags carry", N'(out_carry), 32'd1);
      chk("flags ovf", N'(out_ovf), 32'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      tick();

      // Randomized traffic with varying backpressure.
      for (int phase = 0; phase < 3; phase++) begin
         for (int k = 0; k < 150; k++) begin
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 7) == 0) ? 32'h0 : N'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            out_ready = (phase == 0) ? ($urandom_range(0, 3) != 0) :
                        (phase == 1) ? ($urandom_range(0, 3) == 0) :
                                       1'($urandom_range(0, 1));
            tick();
         end
      end
      drive(1'b0, $urandom, 1'b0, 1'b0);
      out_ready = 1'b1;
      repeat (3) tick();

      // Reset while both entries are full.
      out_ready = 1'b0;
      drive(1'b1, 32'hAAAA_0001, 1'b0, 1'b1);
      tick();
      drive(1'b1, 32'hAAAA_0002, 1'b1, 1'b0);
      tick();
      chk("two in_ready", N'(in_ready), 32'd0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("async rst out_valid", N'(out_valid), 32'd0);
      chk("async rst in_ready", N'(in_ready), 32'd1);
      chk("async rst count", N'(xfer_count), 32'd0);
      chk("async rst result", out_result, 32'd0);
      tick();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      repeat (3) begin
         tick();
         chk("post rst out_valid", N'(out_valid), 32'd0);
         chk("post rst count", N'(xfer_count), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the ALU function units (bitwise NOT/AND/OR, adder). It captures the selected N-bit result, generates zero/negative flags and forwards carry/overflow.
- It presents the result to the consumer (register-file writeback) over a valid/ready handshake.
- A 2-entry skid buffer decouples ALU issue from consumer backpressure while keeping in_ready free of any combinational path from out_ready.

Parameters:
- N, 32, datapath width in bits; must be at least 2.
- CNT_W, 16, width of the transfer counter.

Ports:
- clk  input  1  single clock; all registers update on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  ALU result is valid this cycle.
- in_ready  output  1  stage can accept a result.
- in_result  input  N  ALU result.
- in_carry  input  1  carry-out from the adder; 0 for logic ops.
- in_ovf  input  1  signed overflow from the adder; 0 for logic ops.
- out_valid  output  1  out_* holds a valid result.
- out_ready  input  1  consumer accepts this cycle.
- out_result  output  N  registered result.
- out_zero  output  1  result equals 0.
- out_neg  output  1  result MSB.
- out_carry  output  1  registered carry.
- out_ovf  output  1  registered overflow.
- xfer_count  output  CNT_W  number of completed output transfers.

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low; both are fixed.
- Event definitions:
  - accept = in_valid & in_ready.
  - xfer = out_valid & out_ready.
- Storage:
  - Main register M drives out_*.
  - Skid register S holds {result, zero, neg, carry, ovf}.
- Flag generation at capture time:
  - zero = ~|in_result.
  - neg = in_result[N-1].
  - carry and ovf are copied unchanged.
- States:
  - EMPTY: out_valid = 0.
  - ONE: M valid, S empty.
  - TWO: M and S valid.
- Decoded outputs, taken from the state register only:
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO).
- Transitions:
  - EMPTY: on accept, load M and go to ONE.
  - ONE, accept & ~xfer: load S, go to TWO.
  - ONE, accept & xfer: load M with the new input, stay in ONE.
  - ONE, ~accept & xfer: go to EMPTY.
  - ONE, neither event: hold.
  - TWO, xfer: copy S to M, go to ONE. Accept is impossible because in_ready = 0.
  - TWO, no xfer: hold.
- Latency: a result accepted at edge k appears on out_* after edge k. Minimum latency is 1 cycle; there is no combinational pass-through.
- Throughput: one result per cycle when out_ready is held high.
- Stability: while out_valid & ~out_ready, all out_* hold constant. M updates only on a load.
- Ordering: strict FIFO; no result is dropped or duplicated.
- xfer_count:
  - Increments by 1 on each xfer.
  - Wraps from 2^CNT_W-1 to 0 silently.
  - Does not change on accept alone.
- Reset values, applied immediately when rst_n goes low:
  - state = EMPTY, out_valid = 0, in_ready = 1.
  - out_result = 0, all flags = 0, xfer_count = 0, S = 0.
- Reset mid-operation discards both entries. Buffered results are not counted and never appear after reset is released.
- in_* while in_valid = 0 is don't-care and must not affect any register.

Decomposition:
- Shared package alu_pkg:
  - default N = 32.
  - State encoding: EMPTY = 2'b00, ONE = 2'b01, TWO = 2'b10. 2'b11 is illegal and recovers to EMPTY.
  - Flag bundle layout {zero, neg, carry, ovf} as a 4-bit constant-indexed vector, shared with the writeback and branch units.
- Sub-module alu_flag_gen: combinational; takes in_result and produces zero and neg. It is reused later by the branch comparator.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with in_valid = 1 → out_valid = 0, in_ready = 1, out_result = 0, xfer_count = 0 throughout.
- Single result: out_ready = 1; drive in_result = 0xFFFF_FFFF (NOT of 0) with in_valid for 1 cycle → next cycle out_valid = 1, out_result = 0xFFFF_FFFF, neg = 1, zero = 0. One cycle later out_valid = 0 and xfer_count = 1.
- Backpressure and skid:
  - Set out_ready = 0; push 0x0000_0000, then 0x1234_5678 → in_ready = 0 after the second accept.
  - Offer 0xDEAD_BEEF; it is held off. out_result stays 0x0000_0000 with zero = 1.
  - Raise out_ready → outputs 0x0000_0000, 0x1234_5678, 0xDEAD_BEEF on consecutive cycles; xfer_count = 3.
- Streaming: out_ready = 1, in_valid = 1 for 8 cycles with values 1..8 → 8 consecutive outputs 1..8, in_ready never 0, xfer_count = 8.
- Flag passthrough: in_result = 0x8000_0000, carry = 1, ovf = 1 → out_neg = 1, out_zero = 0, out_carry = 1, out_ovf = 1.
- Reset in TWO state: fill both entries with out_ready = 0, then drop rst_n mid-cycle → out_valid falls immediately without waiting for a clock edge. After release with out_ready = 1, no stale data appears and xfer_count = 0.
